// File: rtl/ctrl_fsm_param.sv
// Multi-cycle control sequencer for the accumulator CPU: fetch/decode/execute/writeback
// with data-memory wait + timeout, skip-if-zero, halt/resume and a retired-instruction count.
module ctrl_fsm_param #(
  parameter int OPCODE_W = 3,
  parameter int OP_HLT   = 0,
  parameter int OP_SKZ   = 1,
  parameter int OP_ADD   = 2,
  parameter int OP_AND   = 3,
  parameter int OP_XOR   = 4,
  parameter int OP_LDA   = 5,
  parameter int OP_STO   = 6,
  parameter int OP_JMP   = 7,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                resume,
  output logic                pc_en,
  output logic                pc_load,
  output logic                halt,
  output logic                accumulator_load,
  output logic                accumulator_control,
  output logic                memIns_en,
  output logic                memDa_en,
  output logic                memDa_we,
  output logic                mem_timeout,
  output logic [CNT_W-1:0]    instr_count,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    SKIP      = 3'd4,
    HALTED    = 3'd5
  } state_t;

  localparam logic [OPCODE_W-1:0] C_HLT = OPCODE_W'(OP_HLT);
  localparam logic [OPCODE_W-1:0] C_SKZ = OPCODE_W'(OP_SKZ);
  localparam logic [OPCODE_W-1:0] C_ADD = OPCODE_W'(OP_ADD);
  localparam logic [OPCODE_W-1:0] C_AND = OPCODE_W'(OP_AND);
  localparam logic [OPCODE_W-1:0] C_XOR = OPCODE_W'(OP_XOR);
  localparam logic [OPCODE_W-1:0] C_LDA = OPCODE_W'(OP_LDA);
  localparam logic [OPCODE_W-1:0] C_STO = OPCODE_W'(OP_STO);
  localparam logic [OPCODE_W-1:0] C_JMP = OPCODE_W'(OP_JMP);

  // The stall that would bring the counter to all-ones is the one that times out.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((2**WAIT_W) - 2);

  state_t              state;
  state_t              state_nxt;
  logic [OPCODE_W-1:0] op_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                timeout_q;
  logic [CNT_W-1:0]    count_q;

  function automatic logic is_acc_op(input logic [OPCODE_W-1:0] op);
    return (op == C_ADD) || (op == C_AND) || (op == C_XOR) || (op == C_LDA);
  endfunction

  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    return is_acc_op(op) || (op == C_STO);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      case (state)
        DECODE: op_q <= opcode;
        EXECUTE: begin
          if (mem_ready) begin
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        WRITEBACK: count_q <= count_q + CNT_W'(1);
        HALTED: if (resume) timeout_q <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        if (opcode == C_HLT)         state_nxt = HALTED;
        else if (is_mem_op(opcode))  state_nxt = EXECUTE;
        else                         state_nxt = WRITEBACK;
      end
      EXECUTE: begin
        if (mem_ready)                   state_nxt = WRITEBACK;
        else if (wait_cnt == WAIT_LAST)  state_nxt = HALTED;
        else                             state_nxt = EXECUTE;
      end
      WRITEBACK: begin
        if (op_q != C_JMP && op_q == C_SKZ && zero) state_nxt = SKIP;
        else                                        state_nxt = FETCH;
      end
      SKIP:    state_nxt = FETCH;
      HALTED:  state_nxt = resume ? WRITEBACK : HALTED;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    pc_en               = 1'b0;
    pc_load             = 1'b0;
    halt                = 1'b0;
    accumulator_load    = 1'b0;
    accumulator_control = 1'b0;
    memIns_en           = 1'b0;
    memDa_en            = 1'b0;
    memDa_we            = 1'b0;
    if (!rst) begin
      case (state)
        FETCH, DECODE: memIns_en = 1'b1;
        EXECUTE: begin
          memDa_en = 1'b1;
          memDa_we = (op_q == C_STO);
          if (mem_ready && is_acc_op(op_q)) begin
            accumulator_load    = 1'b1;
            accumulator_control = (op_q == C_LDA);
          end
        end
        WRITEBACK: begin
          if (op_q == C_JMP) pc_load = 1'b1;
          else               pc_en   = 1'b1;
        end
        SKIP:    pc_en = 1'b1;
        HALTED:  halt  = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_timeout = timeout_q & ~rst;
  assign instr_count = rst ? '0 : count_q;
  assign state_o     = rst ? 3'd0 : state;

endmodule

// File: tb/tb_ctrl_fsm_param.sv
// Randomized scoreboard bench for ctrl_fsm_param: the driver derives each cycle's expected
// outputs from per-instruction timing rules; a negedge monitor pops and compares.
module tb_ctrl_fsm_param;

  typedef struct packed {
    logic [2:0]  st;
    logic        pc_en;
    logic        pc_load;
    logic        halt;
    logic        acc_ld;
    logic        acc_ctl;
    logic        ins_en;
    logic        da_en;
    logic        da_we;
    logic        tmo;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  opcode = '0;
  logic        zero = 1'b0, mem_ready = 1'b0, resume = 1'b0;
  logic        pc_en, pc_load, halt, accumulator_load, accumulator_control;
  logic        memIns_en, memDa_en, memDa_we, mem_timeout;
  logic [15:0] instr_count;
  logic [2:0]  state_o;

  logic        rst2 = 1'b1;
  logic [3:0]  opcode2 = 4'd8;
  logic        pc_en2, pc_load2, halt2, acc_ld2, acc_ctl2, ins_en2, da_en2, da_we2, tmo2;
  logic [1:0]  count2;
  logic [2:0]  state2;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sbq[$];
  logic [15:0] exp_cnt = '0;
  logic        exp_tmo = 1'b0;

  always #5 clk = ~clk;

  ctrl_fsm_param dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .pc_en(pc_en), .pc_load(pc_load), .halt(halt),
    .accumulator_load(accumulator_load), .accumulator_control(accumulator_control),
    .memIns_en(memIns_en), .memDa_en(memDa_en), .memDa_we(memDa_we),
    .mem_timeout(mem_timeout), .instr_count(instr_count), .state_o(state_o)
  );

  ctrl_fsm_param #(.OPCODE_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .opcode(opcode2), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .pc_en(pc_en2), .pc_load(pc_load2), .halt(halt2),
    .accumulator_load(acc_ld2), .accumulator_control(acc_ctl2),
    .memIns_en(ins_en2), .memDa_en(da_en2), .memDa_we(da_we2),
    .mem_timeout(tmo2), .instr_count(count2), .state_o(state2)
  );

  // Monitor: every cycle the DUT presents a full output vector.
  always @(negedge clk) begin
    exp_t e, a;
    a = {state_o, pc_en, pc_load, halt, accumulator_load, accumulator_control,
         memIns_en, memDa_en, memDa_we, mem_timeout, instr_count};
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t actual st=%0d pe=%b pl=%b h=%b al=%b ac=%b ie=%b de=%b we=%b to=%b cnt=%0d required st=%0d pe=%b pl=%b h=%b al=%b ac=%b ie=%b de=%b we=%b to=%b cnt=%0d",
                 $time, a.st, a.pc_en, a.pc_load, a.halt, a.acc_ld, a.acc_ctl, a.ins_en, a.da_en, a.da_we, a.tmo, a.cnt,
                 e.st, e.pc_en, e.pc_load, e.halt, e.acc_ld, e.acc_ctl, e.ins_en, e.da_en, e.da_we, e.tmo, e.cnt);
      end
      n_checks++;
      if (pc_en && pc_load) begin
        n_fail++;
        $display("FAIL pc_exclusive t=%0t actual pc_en=1 pc_load=1 required not both", $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    opcode    = 3'($urandom);
    zero      = 1'($urandom);
    mem_ready = 1'($urandom);
    resume    = 1'($urandom);
  endtask

  function automatic exp_t base(input logic [2:0] st);
    exp_t e = '0;
    e.st     = st;
    e.ins_en = (st == 3'd0) || (st == 3'd1);
    e.halt   = (st == 3'd5);
    e.tmo    = exp_tmo;
    e.cnt    = exp_cnt;
    return e;
  endfunction

  // Retirement cycle, plus the second PC increment when a skip is taken.
  task automatic writeback(input int op, input bit zr);
    exp_t e;
    tick(); rand_in(); zero = zr;
    e = base(3'd3);
    if (op == 7) e.pc_load = 1'b1;
    else         e.pc_en   = 1'b1;
    sbq.push_back(e);
    exp_cnt++;
    if (op == 1 && zr) begin
      tick(); rand_in();
      e = base(3'd4); e.pc_en = 1'b1;
      sbq.push_back(e);
    end
  endtask

  task automatic halted(input int hold);
    for (int i = 0; i < hold; i++) begin
      tick(); rand_in(); resume = (i == hold - 1);
      sbq.push_back(base(3'd5));
    end
    exp_tmo = 1'b0;
    writeback(0, 1'($urandom));
  endtask

  // stalls >= 15 means the memory never answers and the access times out.
  task automatic do_instr(input int op, input int stalls, input bit zr, input int hold);
    exp_t e;
    int   n;
    tick(); rand_in(); rst = 1'b0;
    sbq.push_back(base(3'd0));
    tick(); rand_in(); opcode = 3'(op);
    sbq.push_back(base(3'd1));
    if (op == 0) begin
      halted(hold);
    end else if (op >= 2 && op <= 6) begin
      n = (stalls >= 15) ? 15 : stalls;
      for (int i = 0; i < n; i++) begin
        tick(); rand_in(); mem_ready = 1'b0;
        e = base(3'd2); e.da_en = 1'b1; e.da_we = (op == 6);
        sbq.push_back(e);
      end
      if (stalls >= 15) begin
        exp_tmo = 1'b1;
        halted(hold);
      end else begin
        tick(); rand_in(); mem_ready = 1'b1;
        e = base(3'd2); e.da_en = 1'b1; e.da_we = (op == 6);
        e.acc_ld = (op != 6); e.acc_ctl = (op == 5);
        sbq.push_back(e);
        writeback(op, 1'($urandom));
      end
    end else begin
      writeback(op, (op == 1) ? zr : 1'($urandom));
    end
  endtask

  task automatic check2(input string name, input logic [14:0] act, input logic [14:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      tick(); rand_in(); sbq.push_back('0);
    end
    do_instr(2, 0, 1'b0, 1);
    do_instr(5, 3, 1'b0, 1);
    do_instr(6, 15, 1'b0, 2);
    do_instr(1, 0, 1'b1, 1);
    do_instr(1, 0, 1'b0, 1);
    do_instr(7, 0, 1'b0, 1);
    do_instr(0, 0, 1'b0, 11);

    // Reset in the middle of a stall, then prove the wait counter restarted.
    tick(); rand_in(); sbq.push_back(base(3'd0));
    tick(); rand_in(); opcode = 3'd6; sbq.push_back(base(3'd1));
    for (int i = 0; i < 5; i++) begin
      tick(); rand_in(); mem_ready = 1'b0;
      e = base(3'd2); e.da_en = 1'b1; e.da_we = 1'b1;
      sbq.push_back(e);
    end
    tick(); rand_in(); rst = 1'b1; sbq.push_back('0);
    tick(); rand_in(); sbq.push_back('0);
    exp_cnt = '0; exp_tmo = 1'b0;
    do_instr(6, 14, 1'b0, 1);

    for (int k = 0; k < 60; k++) begin
      do_instr($urandom_range(0, 7),
               ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3),
               1'($urandom), $urandom_range(1, 4));
    end
    tick();

    // Narrow counter: five NOPs must wrap a 2-bit count to 1.
    rst2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); tick(); tick();
      check2("nop_wrap",
             {state2, pc_en2, pc_load2, halt2, acc_ld2, acc_ctl2, ins_en2, da_en2, da_we2, tmo2, count2},
             {3'd0, 5'b00000, 3'b100, 1'b0, 2'((i + 1) % 4)});
    end
    @(negedge clk); #1;
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ctrl_fsm_param.md
Name: ctrl_fsm_param

Overview:
Parametrised multi-cycle control sequencer for the accumulator CPU. It is the successor of the fixed 4-state one-hot controller and adds:
- generic opcode width and encodings;
- a data-memory ready handshake with timeout;
- conditional skip (SKZ) on the accumulator zero flag;
- halt with resume;
- a retired-instruction counter.
It sits between instruction memory/decoder, PC, accumulator and data memory.

Parameters:
OPCODE_W, 3, opcode width
OP_HLT, 0, halt encoding
OP_SKZ, 1, skip-next-if-accumulator-zero encoding
OP_ADD, 2, acc <= acc + mem
OP_AND, 3, acc <= acc & mem
OP_XOR, 4, acc <= acc ^ mem
OP_LDA, 5, acc <= mem
OP_STO, 6, mem <= acc
OP_JMP, 7, pc <= operand
WAIT_W, 4, width of memory wait counter; timeout after 2**WAIT_W-1 stalled cycles
CNT_W, 16, width of retired-instruction counter
Any opcode value not matching a parameter is treated as NOP.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
opcode  in  OPCODE_W  opcode from instruction memory, valid in DECODE
zero  in  1  accumulator == 0 flag
mem_ready  in  1  data memory completed access
resume  in  1  leave HALTED
pc_en  out  1  PC increment
pc_load  out  1  PC load from operand
halt  out  1  processor halted
accumulator_load  out  1  accumulator write strobe
accumulator_control  out  1  1: acc source = memory (LDA); 0: ALU result
memIns_en  out  1  instruction memory enable
memDa_en  out  1  data memory enable
memDa_we  out  1  data memory write enable
mem_timeout  out  1  sticky memory-timeout error
instr_count  out  CNT_W  retired-instruction count
state_o  out  3  encoded state, for debug

Behaviour:
- Reset:
  - While rst=1, every output is 0, including mem_timeout, instr_count and the wait counter.
  - On the first clock with rst=0 after reset, the state is FETCH.
- Outputs are combinational from the state register plus the latched opcode op_q.
- States and encodings:
  - FETCH (0): memIns_en=1. Next state is DECODE.
  - DECODE (1): memIns_en=1; op_q <= opcode. Next state is chosen from the incoming opcode:
    - HLT -> HALTED;
    - ADD/AND/XOR/LDA/STO -> EXECUTE;
    - JMP, SKZ, NOP -> WRITEBACK.
  - EXECUTE (2): memDa_en=1; memDa_we=1 iff op_q=STO.
    - mem_ready=0: the wait counter increments. If the counter equals 2**WAIT_W-1, set mem_timeout and go to HALTED.
    - mem_ready=1: the counter clears and the state goes to WRITEBACK. In this same cycle, accumulator_load=1 for ADD/AND/XOR/LDA, with accumulator_control=1 only for LDA.
  - WRITEBACK (3): instr_count increments and wraps at 2**CNT_W.
    - JMP: pc_load=1, pc_en=0 -> FETCH.
    - SKZ with zero=1: pc_en=1 -> SKIP.
    - Otherwise: pc_en=1 -> FETCH.
  - SKIP (4): pc_en=1 (second increment) -> FETCH.
  - HALTED (5): halt=1, all other strobes 0.
    - resume=1: clear mem_timeout, then go to WRITEBACK so the PC advances past the halting instruction. That WRITEBACK uses op_q.
    - resume=0: stay in HALTED.
- Latencies:
  - ALU/LDA/STO with immediate ready: 4 cycles.
  - JMP/NOP/SKZ not taken: 3 cycles.
  - SKZ taken: 4 cycles.
  - Each stall cycle adds 1.
- Input qualification:
  - resume is ignored outside HALTED.
  - mem_ready is ignored outside EXECUTE.
  - zero is sampled only in WRITEBACK.
  - opcode is sampled only in DECODE.
- pc_en and pc_load are never both 1.
- Reset mid-operation (including mid-stall) aborts with no strobes asserted on the next cycle.
- HLT retires through WRITEBACK on resume, so it is counted then, not at DECODE.
- Unused state encodings 6-7 go to FETCH with all outputs 0.

Test Plan:
- Reset, then ADD (opcode 2) with mem_ready held 1 -> state sequence 0,1,2,3,0; accumulator_load=1 only in the EXECUTE cycle with control=0; pc_en=1 in WRITEBACK; instr_count=1.
- LDA (opcode 5) with mem_ready low for 3 cycles -> EXECUTE lasts 4 cycles; accumulator_load=1, control=1 only on the ready cycle; no timeout.
- STO (opcode 6) with mem_ready never asserted, WAIT_W=4 -> memDa_we=1 through EXECUTE; after 15 stall cycles mem_timeout=1 and halt=1. resume -> mem_timeout=0, one pc_en pulse, FETCH.
- SKZ (opcode 1) with zero=1 -> pc_en high on 2 consecutive cycles (WRITEBACK, SKIP). With zero=0 -> single pc_en pulse, 3-cycle instruction.
- JMP (opcode 7) -> pc_load=1, pc_en=0 in WRITEBACK. HLT (opcode 0) -> halt stays 1 for 10 cycles; resume=1 -> next cycle WRITEBACK with pc_en=1, instr_count incremented.
- rst asserted during an EXECUTE stall -> all outputs 0 on the next cycle; wait counter and instr_count are 0; FETCH on release. CNT_W=2 with 5 NOP instructions -> instr_count wraps to 1.
